// File: rtl/pipelined_dual_port_ram_if.sv
// Bus bundle for pipelined_dual_port_ram: control, one read port and one byte-masked write port.
// TIA_WORD_WIDTH supplies the default word width when the build does not define it.
`ifndef TIA_WORD_WIDTH
`define TIA_WORD_WIDTH 32
`endif

interface pipelined_dual_port_ram_if #(
  parameter int WIDTH      = `TIA_WORD_WIDTH,
  parameter int DEPTH      = 1024,
  parameter int BYTE_WIDTH = 8
);
  localparam int AW    = $clog2(DEPTH);
  localparam int LANES = WIDTH / BYTE_WIDTH;

  logic             clear;
  logic             ready;
  logic             read_enable;
  logic [AW-1:0]    read_index;
  logic             read_valid;
  logic [WIDTH-1:0] read_data;
  logic             write_enable;
  logic [AW-1:0]    write_index;
  logic [LANES-1:0] write_mask;
  logic [WIDTH-1:0] write_data;

  modport master (
    output clear, read_enable, read_index, write_enable, write_index, write_mask, write_data,
    input  ready, read_valid, read_data
  );

  modport slave (
    input  clear, read_enable, read_index, write_enable, write_index, write_mask, write_data,
    output ready, read_valid, read_data
  );
endinterface

// File: rtl/pipelined_dual_port_ram.sv
// Byte-masked 1R1W block RAM with a zeroing sweep after reset or clear, read latency 1 or 2.
// Macro RAM_WRITE_FORWARDING_EN merges a same-cycle, same-index write into the read result.
`ifndef TIA_WORD_WIDTH
`define TIA_WORD_WIDTH 32
`endif

module pipelined_dual_port_ram #(
  parameter int WIDTH        = `TIA_WORD_WIDTH,
  parameter int DEPTH        = 1024,
  parameter int BYTE_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic clock,
  input  logic reset,
  pipelined_dual_port_ram_if.slave bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int LANES = WIDTH / BYTE_WIDTH;
  localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] clear_index_q, clear_index_d;

  logic [WIDTH-1:0] ram [DEPTH];

  logic rd_in_range, wr_in_range, rd_fire, wr_fire;

  assign rd_in_range = {1'b0, bus.read_index}  < DEPTH_EXT;
  assign wr_in_range = {1'b0, bus.write_index} < DEPTH_EXT;
  assign rd_fire     = (state_q == READY) && bus.read_enable;
  // A write coinciding with clear is dropped so the sweep starts from a known image.
  assign wr_fire     = (state_q == READY) && bus.write_enable && !bus.clear && wr_in_range;
  assign bus.ready   = (state_q == READY);

  always_comb begin
    state_d       = state_q;
    clear_index_d = clear_index_q;
    unique case (state_q)
      CLEAR: begin
        clear_index_d = clear_index_q + AW'(1);
        if (clear_index_q == LAST_IDX) begin
          state_d       = READY;
          clear_index_d = '0;
        end
      end
      READY: begin
        if (bus.clear) begin
          state_d       = CLEAR;
          clear_index_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= CLEAR;
      clear_index_q <= '0;
    end else begin
      state_q       <= state_d;
      clear_index_q <= clear_index_d;
    end
  end

  // Array write port: sweep zeroing or byte-lane masked write, no reset on contents.
  always_ff @(posedge clock) begin
    if (state_q == CLEAR) begin
      ram[clear_index_q] <= '0;
    end else if (wr_fire) begin
      for (int l = 0; l < LANES; l++) begin
        if (bus.write_mask[l]) begin
          ram[bus.write_index][l*BYTE_WIDTH +: BYTE_WIDTH] <= bus.write_data[l*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Stage p0: synchronous array read (read-first) plus its control tags.
  logic [WIDTH-1:0] word_p0;
  logic             vld_p0;
  logic             hit_p0;
  logic [WIDTH-1:0] merged_p0;
  logic [WIDTH-1:0] result_p0;

  always_ff @(posedge clock) begin
    if (rd_fire && rd_in_range) begin
      word_p0 <= ram[bus.read_index];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      hit_p0 <= 1'b0;
    end else begin
      vld_p0 <= rd_fire;
      hit_p0 <= rd_fire && rd_in_range;
    end
  end

`ifdef RAM_WRITE_FORWARDING_EN
  logic             fwd_p0;
  logic [LANES-1:0] fwd_mask_p0;
  logic [WIDTH-1:0] fwd_data_p0;

  function automatic logic [WIDTH-1:0] merge_lanes(input logic [WIDTH-1:0] old_word,
                                                   input logic [WIDTH-1:0] new_word,
                                                   input logic [LANES-1:0] mask);
    logic [WIDTH-1:0] w;
    w = old_word;
    for (int l = 0; l < LANES; l++) begin
      if (mask[l]) w[l*BYTE_WIDTH +: BYTE_WIDTH] = new_word[l*BYTE_WIDTH +: BYTE_WIDTH];
    end
    return w;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fwd_p0 <= 1'b0;
    end else begin
      fwd_p0 <= rd_fire && wr_fire && (bus.read_index == bus.write_index);
    end
  end

  always_ff @(posedge clock) begin
    if (rd_fire) begin
      fwd_mask_p0 <= bus.write_mask;
      fwd_data_p0 <= bus.write_data;
    end
  end

  assign merged_p0 = fwd_p0 ? merge_lanes(word_p0, fwd_data_p0, fwd_mask_p0) : word_p0;
`else
  assign merged_p0 = word_p0;
`endif

  // Out-of-range reads still report valid, but with a zero word.
  assign result_p0 = hit_p0 ? merged_p0 : '0;

  // Stage p1 (READ_LATENCY=2 only): output register with a matching valid.
  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic             vld_p1;
      logic [WIDTH-1:0] data_p1;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) vld_p1 <= 1'b0;
        else       vld_p1 <= vld_p0;
      end

      always_ff @(posedge clock) begin
        data_p1 <= result_p0;
      end

      assign bus.read_valid = vld_p1;
      assign bus.read_data  = vld_p1 ? data_p1 : '0;
    end else begin : g_lat1
      assign bus.read_valid = vld_p0;
      assign bus.read_data  = result_p0;
    end
  endgenerate
endmodule
